// File: rtl/axi4lite_reg_pkg.sv
// Shared definitions for the AXI4-Lite register slave: register offsets,
// response codes, FSM state types and the byte-strobe merge helper.
package axi4lite_reg_pkg;

  // Register index is address bits [4:2]
  localparam logic [2:0] REG_ID      = 3'd0;
  localparam logic [2:0] REG_SCRATCH = 3'd1;
  localparam logic [2:0] REG_CTRL    = 3'd2;
  localparam logic [2:0] REG_STATUS  = 3'd3;
  localparam logic [2:0] REG_COUNT   = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle. Handshake rule on every channel: a beat transfers on
// the rising edge where valid && ready; the sender holds valid and payload
// stable until then, and ready may depend only on the receiver's state.
interface axi4lite_reg_slave_if #(parameter int ADDR_W = 12);
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register file for the PS: ID, scratch, control, sampled status and
// a free-running cycle counter; independent single-outstanding read/write paths.
module axi4lite_reg_slave
  import axi4lite_reg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5250_0001
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  axi4lite_reg_slave_if.slave         s_axi,
  output logic [31:0]                 ctrl_o,
  input  logic [31:0]                 status_i,
  output w_state_e                    w_state_o,
  output r_state_e                    r_state_o
);

  w_state_e    w_state_q, w_state_d;
  r_state_e    r_state_q, r_state_d;
  logic        aw_held_q, aw_held_d;
  logic [2:0]  aw_off_q,  aw_off_d;
  logic        w_held_q,  w_held_d;
  logic [31:0] wdata_q,   wdata_d;
  logic [3:0]  wstrb_q,   wstrb_d;
  logic [1:0]  bresp_q,   bresp_d;
  logic [31:0] rdata_q,   rdata_d;
  logic [1:0]  rresp_q,   rresp_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] ctrl_q,    ctrl_d;
  logic [31:0] count_q,   count_d;

  logic aw_hs, w_hs;

  assign s_axi.awready = !aw_held_q && (w_state_q == W_IDLE);
  assign s_axi.wready  = !w_held_q  && (w_state_q == W_IDLE);
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (r_state_q == R_IDLE);
  assign s_axi.rvalid  = (r_state_q == R_RESP);
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;
  assign ctrl_o        = ctrl_q;
  assign w_state_o     = w_state_q;
  assign r_state_o     = r_state_q;

  assign aw_hs = s_axi.awvalid && s_axi.awready;
  assign w_hs  = s_axi.wvalid  && s_axi.wready;

  always_comb begin
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    aw_held_d = aw_held_q;
    aw_off_d  = aw_off_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    scratch_d = scratch_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q + 32'd1;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_off_d  = s_axi.awaddr[4:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi.wdata;
      wstrb_d  = s_axi.wstrb;
    end

    // Commit uses the _d copies so a same-cycle AW/W handshake commits at once
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_held_d && w_held_d) begin
          w_state_d = W_RESP;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = RESP_SLVERR;
          if (aw_off_d == REG_SCRATCH) begin
            scratch_d = apply_strb(scratch_q, wdata_d, wstrb_d);
            bresp_d   = RESP_OKAY;
          end else if (aw_off_d == REG_CTRL) begin
            ctrl_d  = apply_strb(ctrl_q, wdata_d, wstrb_d);
            bresp_d = RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase

    // Read mux samples the current flops, so a same-edge write is not visible
    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          r_state_d = R_RESP;
          rresp_d   = RESP_OKAY;
          unique case (s_axi.araddr[4:2])
            REG_ID:      rdata_d = ID_VALUE;
            REG_SCRATCH: rdata_d = scratch_q;
            REG_CTRL:    rdata_d = ctrl_q;
            REG_STATUS:  rdata_d = status_i;
            REG_COUNT:   rdata_d = count_q;
            default: begin
              rdata_d = 32'd0;
              rresp_d = RESP_SLVERR;
            end
          endcase
        end
      end
      R_RESP: begin
        if (s_axi.rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_held_q <= 1'b0;
      aw_off_q  <= 3'd0;
      w_held_q  <= 1'b0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      bresp_q   <= RESP_OKAY;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
      scratch_q <= 32'd0;
      ctrl_q    <= 32'd0;
      count_q   <= 32'd0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_held_q <= aw_held_d;
      aw_off_q  <= aw_off_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      scratch_q <= scratch_d;
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for axi4lite_reg_slave: register map, strobes, error responses,
// backpressure, same-edge read/write ordering and mid-transaction reset.
module tb_axi4lite_reg_slave;
  import axi4lite_reg_pkg::*;

  logic        clk_i;
  logic        rst_i;
  logic [31:0] ctrl_o;
  logic [31:0] status_i;
  w_state_e    w_state_o;
  r_state_e    r_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  axi4lite_reg_slave_if #(.ADDR_W(12)) bus ();

  axi4lite_reg_slave #(.ID_VALUE(32'h5250_0001)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .s_axi     (bus.slave),
    .ctrl_o    (ctrl_o),
    .status_i  (status_i),
    .w_state_o (w_state_o),
    .r_state_o (r_state_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks: called and return on a falling edge
  task automatic do_read(input logic [11:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    check("arready_idle", 32'(bus.arready), 32'd1);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    @(negedge clk_i);
    bus.arvalid = 1'b0;
    check("rvalid_set", 32'(bus.rvalid), 32'd1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk_i);
    bus.rready = 1'b0;
    check("rvalid_clr", 32'(bus.rvalid), 32'd0);
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp,
                          output logic [31:0] ctrl_snap);
    bus.awaddr  = addr;
    bus.awvalid = 1'b1;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.wvalid  = 1'b1;
    @(negedge clk_i);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("bvalid_set", 32'(bus.bvalid), 32'd1);
    resp      = bus.bresp;
    ctrl_snap = ctrl_o;
    bus.bready = 1'b1;
    @(negedge clk_i);
    bus.bready = 1'b0;
    check("bvalid_clr", 32'(bus.bvalid), 32'd0);
  endtask

  logic [31:0] rd, rd2, cs;
  logic [1:0]  rr, br;

  initial begin
    rst_i       = 1'b1;
    status_i    = 32'd0;
    bus.awaddr  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    #1;
    check("rst_awready", 32'(bus.awready), 32'd1);
    check("rst_wready",  32'(bus.wready),  32'd1);
    check("rst_arready", 32'(bus.arready), 32'd1);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    check("rst_ctrl",    ctrl_o,           32'd0);
    check("rst_wstate",  32'(w_state_o),   32'(W_IDLE));
    check("rst_rstate",  32'(r_state_o),   32'(R_IDLE));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    // ID and counter spacing: AR edges are 7 cycles apart
    do_read(12'h000, rd, rr);
    check("id_data", rd, 32'h5250_0001);
    check("id_resp", 32'(rr), 32'(RESP_OKAY));
    do_read(12'h010, rd, rr);
    check("cnt_resp", 32'(rr), 32'(RESP_OKAY));
    repeat (5) @(negedge clk_i);
    do_read(12'h010, rd2, rr);
    check("cnt_delta", rd2 - rd, 32'd7);

    // AW at cycle 0, W at cycle 3, B at cycle 4
    bus.awaddr  = 12'h004;
    bus.awvalid = 1'b1;
    @(negedge clk_i);
    bus.awvalid = 1'b0;
    check("split_awready", 32'(bus.awready), 32'd0);
    check("split_wready",  32'(bus.wready),  32'd1);
    check("split_bvalid0", 32'(bus.bvalid),  32'd0);
    @(negedge clk_i);
    check("split_bvalid1", 32'(bus.bvalid),  32'd0);
    @(negedge clk_i);
    check("split_bvalid2", 32'(bus.bvalid),  32'd0);
    bus.wdata  = 32'hDEAD_BEEF;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    @(negedge clk_i);
    bus.wvalid = 1'b0;
    check("split_bvalid4", 32'(bus.bvalid), 32'd1);
    check("split_bresp",   32'(bus.bresp),  32'(RESP_OKAY));
    bus.bready = 1'b1;
    @(negedge clk_i);
    bus.bready = 1'b0;
    check("split_bvalid_clr", 32'(bus.bvalid),  32'd0);
    check("split_awready_rt", 32'(bus.awready), 32'd1);
    check("split_wready_rt",  32'(bus.wready),  32'd1);
    do_read(12'h004, rd, rr);
    check("scratch_rd", rd, 32'hDEAD_BEEF);
    do_read(12'h007, rd, rr);
    check("scratch_lowbits", rd, 32'hDEAD_BEEF);

    // CTRL with byte strobes
    do_write(12'h008, 32'h1122_3344, 4'b0101, br, cs);
    check("ctrl_bresp", 32'(br), 32'(RESP_OKAY));
    check("ctrl_strb1", cs, 32'h0022_0044);
    do_write(12'h008, 32'hAABB_CCDD, 4'b1010, br, cs);
    check("ctrl_strb2", cs, 32'hAA22_CC44);

    // error responses
    do_write(12'h000, 32'hFFFF_FFFF, 4'hF, br, cs);
    check("wr_id_slverr", 32'(br), 32'(RESP_SLVERR));
    do_read(12'h000, rd, rr);
    check("id_unchanged", rd, 32'h5250_0001);
    do_write(12'h00C, 32'hFFFF_FFFF, 4'hF, br, cs);
    check("wr_status_slverr", 32'(br), 32'(RESP_SLVERR));
    do_write(12'h014, 32'hFFFF_FFFF, 4'hF, br, cs);
    check("wr_unmapped_slverr", 32'(br), 32'(RESP_SLVERR));
    check("ctrl_kept", cs, 32'hAA22_CC44);
    do_read(12'h01C, rd, rr);
    check("rd_unmapped_resp", 32'(rr), 32'(RESP_SLVERR));
    check("rd_unmapped_data", rd, 32'd0);

    status_i = 32'h1234_5678;
    do_read(12'h00C, rd, rr);
    check("status_rd", rd, 32'h1234_5678);

    // rdata held under rready backpressure
    bus.araddr  = 12'h008;
    bus.arvalid = 1'b1;
    @(negedge clk_i);
    bus.arvalid = 1'b0;
    status_i    = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("rhold_rvalid",  32'(bus.rvalid),  32'd1);
      check("rhold_rdata",   bus.rdata,        32'hAA22_CC44);
      check("rhold_arready", 32'(bus.arready), 32'd0);
      @(negedge clk_i);
    end
    bus.rready = 1'b1;
    @(negedge clk_i);
    bus.rready = 1'b0;
    check("rhold_rvalid_clr", 32'(bus.rvalid),  32'd0);
    check("rhold_arready_rt", 32'(bus.arready), 32'd1);

    // bready held low for 10 cycles
    bus.awaddr  = 12'h004;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'hA5A5_5A5A;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    @(negedge clk_i);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bhold_bvalid",  32'(bus.bvalid),  32'd1);
      check("bhold_awready", 32'(bus.awready), 32'd0);
      check("bhold_wready",  32'(bus.wready),  32'd0);
      check("bhold_bresp",   32'(bus.bresp),   32'(RESP_OKAY));
      @(negedge clk_i);
    end
    bus.bready = 1'b1;
    @(negedge clk_i);
    bus.bready = 1'b0;
    check("bhold_awready_rt", 32'(bus.awready), 32'd1);

    // AR and write commit on the same edge: read sees the old value
    bus.awaddr  = 12'h004;
    bus.awvalid = 1'b1;
    bus.wdata   = 32'h0BAD_F00D;
    bus.wstrb   = 4'hF;
    bus.wvalid  = 1'b1;
    bus.araddr  = 12'h004;
    bus.arvalid = 1'b1;
    @(negedge clk_i);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.arvalid = 1'b0;
    check("same_edge_rdata",  bus.rdata,       32'hA5A5_5A5A);
    check("same_edge_bvalid", 32'(bus.bvalid), 32'd1);
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk_i);
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    do_read(12'h004, rd, rr);
    check("same_edge_after", rd, 32'h0BAD_F00D);

    // reset with AW held and W pending
    bus.awaddr  = 12'h004;
    bus.awvalid = 1'b1;
    @(negedge clk_i);
    bus.awvalid = 1'b0;
    check("mid_aw_held", 32'(bus.awready), 32'd0);
    bus.wdata  = 32'hFFFF_0000;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    rst_i      = 1'b1;
    #1;
    check("mid_rst_awready", 32'(bus.awready), 32'd1);
    check("mid_rst_wready",  32'(bus.wready),  32'd1);
    check("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("mid_rst_rdata",   bus.rdata,        32'd0);
    check("mid_rst_ctrl",    ctrl_o,           32'd0);
    @(negedge clk_i);
    bus.wvalid = 1'b0;
    rst_i      = 1'b0;
    @(negedge clk_i);
    check("mid_no_commit", 32'(bus.bvalid), 32'd0);
    do_read(12'h004, rd, rr);
    check("mid_scratch", rd, 32'd0);
    do_read(12'h008, rd, rr);
    check("mid_ctrl_rd", rd, 32'd0);
    do_write(12'h004, 32'h1357_9BDF, 4'hF, br, cs);
    check("post_rst_bresp", 32'(br), 32'(RESP_OKAY));
    do_read(12'h004, rd, rr);
    check("post_rst_rd", rd, 32'h1357_9BDF);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite responder giving the PS a small PL register file through the GP master port of the processing-system block. It answers PS-initiated reads and writes with one outstanding transaction per direction. It provides an ID word, a scratch register, a control word driven to PL logic, a sampled status word and a free-running cycle counter. It sits beside the system block in the top module, on the PS clock domain.

## Interface
- ADDR_W, 12: AXI address width; only bits [4:2] decode registers.
- ID_VALUE, 32'h5250_0001: constant returned at offset 0x00.
- clk_i  in  1  PL clock (FCLK from PS); all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- s_axi_awaddr  in  ADDR_W; s_axi_awvalid in 1; s_axi_awready out 1.
- s_axi_wdata  in  32; s_axi_wstrb in 4; s_axi_wvalid in 1; s_axi_wready out 1.
- s_axi_bresp  out  2; s_axi_bvalid out 1; s_axi_bready in 1.
- s_axi_araddr  in  ADDR_W; s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata  out  32; s_axi_rresp out 2; s_axi_rvalid out 1; s_axi_rready in 1.
- ctrl_o  out  32  control register contents.
- status_i  in  32  PL status, synchronous to clk_i.

## Operation
- Register map (byte offsets): 0x00 ID (RO), 0x04 SCRATCH (RW), 0x08 CTRL (RW, drives ctrl_o), 0x0C STATUS (RO, status_i), 0x10 COUNT (RO). Address bits [1:0] are ignored.
- COUNT: 32-bit, +1 every cycle, wraps 0xFFFF_FFFF→0.
- Writes: AW and W are captured independently, in either order or in the same cycle. The write commits once both are held. Each byte lane i is written only when wstrb[i]=1.
- Write response: OKAY (2'b00) for SCRATCH and CTRL. SLVERR (2'b10) for RO or unmapped offsets, with no state change.
- Reads: a mapped offset returns OKAY and its value. An unmapped offset returns SLVERR with rdata=0.
- Write FSM: W_IDLE (capturing) → W_RESP (bvalid=1) when both halves are held. W_RESP → W_IDLE on the bready handshake.
- Read FSM: R_IDLE → R_RESP on the AR handshake. R_RESP → R_IDLE on the rready handshake.
- Read and write paths are fully independent.

## Timing
- Reset values: awready=wready=arready=1; bvalid=rvalid=0; bresp=rresp=0; rdata=0; SCRATCH=CTRL=0 (ctrl_o=0); COUNT=0.
- awready = !aw_held && !bvalid; wready = !w_held && !bvalid (combinational from state).
- Write latency: the last of AW/W handshakes at edge T gives, at T+1, bvalid=1 with bresp valid and the register/ctrl_o updated.
- bvalid and bresp stay stable until bready. awready and wready return high in the cycle after the B handshake.
- arready = !rvalid. AR handshake at edge T gives rvalid=1 and rdata/rresp at T+1, held until rready.
- Back-to-back throughput is 1 transaction per 2 cycles per direction when the master always holds ready/valid.
- STATUS and COUNT return the value present at the AR handshake edge.
- If AR and a write commit to the same register fall on the same edge, the read returns the pre-write value.
- Asserting rst_i mid-transaction aborts immediately. All outputs go to their reset values and no partial write is committed.

## Structure
- Package axi4lite_reg_pkg holds:
  - offset localparams (REG_ID, REG_SCRATCH, REG_CTRL, REG_STATUS, REG_COUNT);
  - response codes RESP_OKAY and RESP_SLVERR;
  - typedef enums for the write and read FSM states.
- No sub-module: the write capture, read path and register file are small enough to stay in one module.

## Test plan
- After reset, read 0x00 → rdata=32'h5250_0001, rresp=OKAY. Read 0x10 twice, 5 cycles apart → second value minus first = 5 plus handshake spacing.
- AW to 0x04 at cycle 0, W of 32'hDEAD_BEEF with wstrb=4'hF at cycle 3 → bvalid at cycle 4, OKAY. Read 0x04 → 32'hDEAD_BEEF.
- Write 0x08 with data 32'h1122_3344 and wstrb=4'b0101 over CTRL=0 → ctrl_o=32'h0022_0044 one cycle after both handshakes.
- Write 0x00 → bresp=SLVERR and ID unchanged. Read 0x1C → rresp=SLVERR, rdata=0.
- Hold bready=0 for 10 cycles after a write → bvalid stays high, awready/wready stay low, bresp stays stable.
- Assert rst_i while aw_held=1 and W is pending → SCRATCH unchanged, all outputs at reset values, the next transaction completes normally.
